// File: rtl/cache_sp_ram_pkg.sv
// Shared cache geometry constants and the lane-width helper used by the way RAMs.
// Pure declarations: no latency and no flow control.
package cache_sp_ram_pkg;

    localparam int CACHE_INDEX_W  = 8;
    localparam int CACHE_OFFSET_W = 4;
    localparam int CACHE_TAG_W    = 20;
    localparam int CACHE_TAGV_W   = 21;
    localparam int CACHE_BANK_W   = 32;
    localparam int CACHE_BANKS    = 4;

    // The last lane absorbs whatever is left when DATA_W does not divide evenly.
    function automatic int lane_width(input int data_w, input int we_w);
        return (data_w + we_w - 1) / we_w;
    endfunction

endpackage

// File: rtl/cache_sp_ram_if.sv
// Single-port RAM access bundle: the cache way (master) drives the request, the RAM (slave) returns douta.
// No handshake: the caller owns the port every cycle it asserts ena.
interface cache_sp_ram_if
    import cache_sp_ram_pkg::*;
#(
    parameter int DATA_W = CACHE_BANK_W,
    parameter int ADDR_W = CACHE_INDEX_W,
    parameter int WE_W   = CACHE_BANKS
) ();

    logic              ena;
    logic [WE_W-1:0]   wea;
    logic [ADDR_W-1:0] addra;
    logic [DATA_W-1:0] dina;
    logic [DATA_W-1:0] douta;

    modport master (
        output ena,
        output wea,
        output addra,
        output dina,
        input  douta
    );

    modport slave (
        input  ena,
        input  wea,
        input  addra,
        input  dina,
        output douta
    );

endinterface

// File: rtl/cache_sp_ram.sv
// Read-first single-port RAM with per-lane write enables; douta is registered, 1-cycle read latency.
// Never stalls: every enabled cycle performs its read and lane writes at the rising edge.
module cache_sp_ram
    import cache_sp_ram_pkg::*;
#(
    parameter int DATA_W = CACHE_BANK_W,
    parameter int ADDR_W = CACHE_INDEX_W,
    parameter int WE_W   = CACHE_BANKS
) (
    input  logic          clka,
    input  logic          rsta,
    cache_sp_ram_if.slave ram
);

    localparam int DEPTH  = 1 << ADDR_W;
    localparam int LANE_W = lane_width(DATA_W, WE_W);

    logic [DATA_W-1:0] mem_q [DEPTH] = '{default: '0};
    logic [DATA_W-1:0] dout_q;
    logic [DATA_W-1:0] dout_d;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] wr_mask;
    logic [DATA_W-1:0] wr_dat_d;
    logic              wr_en;

    for (genvar k = 0; k < WE_W; k++) begin : g_lane
        localparam int LO = k * LANE_W;
        localparam int HI = (LO + LANE_W > DATA_W) ? DATA_W : LO + LANE_W;
        if (LO < DATA_W) begin : g_used
            assign wr_mask[HI-1:LO] = {(HI - LO){ram.wea[k]}};
        end
    end

    assign rd_word  = mem_q[ram.addra];
    assign wr_dat_d = (rd_word & ~wr_mask) | (ram.dina & wr_mask);
    assign wr_en    = !rsta && ram.ena && (|ram.wea);
    assign dout_d   = ram.ena ? rd_word : dout_q;

    always_ff @(posedge clka) begin
        if (wr_en) begin
            mem_q[ram.addra] <= wr_dat_d;
        end
    end

    // rd_word is sampled from the pre-write contents, giving read-first behaviour.
    always_ff @(posedge clka) begin
        if (rsta) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign ram.douta = dout_q;

endmodule

// File: tb/tb_cache_sp_ram.sv
// Drives a data-bank and a tag/valid instance side by side: directed vectors, then random traffic vs. a byte-array model.
module tb_cache_sp_ram;
    import cache_sp_ram_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cache_sp_ram_if #(.DATA_W(32), .ADDR_W(8), .WE_W(4)) dbus ();
    cache_sp_ram_if #(.DATA_W(21), .ADDR_W(8), .WE_W(1)) tbus ();

    cache_sp_ram #(.DATA_W(32), .ADDR_W(8), .WE_W(4)) u_data (
        .clka (clk),
        .rsta (rst),
        .ram  (dbus)
    );

    cache_sp_ram #(.DATA_W(21), .ADDR_W(8), .WE_W(1)) u_tagv (
        .clka (clk),
        .rsta (rst),
        .ram  (tbus)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0]  md [256];
    logic [20:0] mt [256];
    logic [31:0] exp_d;
    logic [20:0] exp_t;

    typedef struct {
        logic        r;
        logic        en;
        logic [3:0]  we;
        logic [7:0]  a;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    vec_t vt [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Apply one cycle to both instances; the model works on individual bytes of a flat array.
    task automatic step(input logic r,
                        input logic de, input logic [3:0] dw, input logic [7:0] da, input logic [31:0] dd,
                        input logic te, input logic tw, input logic [7:0] ta, input logic [20:0] td);
        rst        = r;
        dbus.ena   = de;
        dbus.wea   = dw;
        dbus.addra = da;
        dbus.dina  = dd;
        tbus.ena   = te;
        tbus.wea   = tw;
        tbus.addra = ta;
        tbus.dina  = td;
        if (r) begin
            exp_d = '0;
            exp_t = '0;
        end else begin
            if (de) begin
                exp_d = {md[{da, 2'd3}], md[{da, 2'd2}], md[{da, 2'd1}], md[{da, 2'd0}]};
                for (int k = 0; k < 4; k++)
                    if (dw[k]) md[{da, k[1:0]}] = dd[8*k +: 8];
            end
            if (te) begin
                exp_t = mt[ta];
                if (tw) mt[ta] = td;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic tag_step(input logic te, input logic tw, input logic [7:0] ta, input logic [20:0] td);
        step(1'b0, 1'b0, 4'h0, 8'h00, 32'h0, te, tw, ta, td);
    endtask

    initial begin
        foreach (md[i]) md[i] = '0;
        foreach (mt[i]) mt[i] = '0;
        exp_d = '0;
        exp_t = '0;

        vt[0]  = '{1'b1, 1'b0, 4'h0, 8'h00, 32'h00000000, 32'h00000000};
        vt[1]  = '{1'b0, 1'b1, 4'hF, 8'h12, 32'hDEADBEEF, 32'h00000000};
        vt[2]  = '{1'b0, 1'b1, 4'h0, 8'h12, 32'h00000000, 32'hDEADBEEF};
        vt[3]  = '{1'b0, 1'b1, 4'hF, 8'h05, 32'h11223344, 32'h00000000};
        vt[4]  = '{1'b0, 1'b1, 4'h5, 8'h05, 32'hAABBCCDD, 32'h11223344};
        vt[5]  = '{1'b0, 1'b1, 4'h0, 8'h05, 32'h00000000, 32'h11BB33DD};
        vt[6]  = '{1'b0, 1'b1, 4'hF, 8'h20, 32'h0000CAFE, 32'h00000000};
        vt[7]  = '{1'b0, 1'b1, 4'h0, 8'h20, 32'h00000000, 32'h0000CAFE};
        vt[8]  = '{1'b0, 1'b1, 4'hF, 8'h20, 32'h12345678, 32'h0000CAFE};
        vt[9]  = '{1'b0, 1'b1, 4'h0, 8'h20, 32'h00000000, 32'h12345678};
        vt[10] = '{1'b0, 1'b0, 4'hF, 8'h12, 32'hFFFFFFFF, 32'h12345678};
        vt[11] = '{1'b0, 1'b1, 4'h0, 8'h12, 32'h00000000, 32'hDEADBEEF};
        vt[12] = '{1'b1, 1'b1, 4'hF, 8'h12, 32'h55555555, 32'h00000000};
        vt[13] = '{1'b0, 1'b0, 4'h0, 8'h12, 32'h00000000, 32'h00000000};
        vt[14] = '{1'b0, 1'b1, 4'h0, 8'h12, 32'h00000000, 32'hDEADBEEF};

        for (int i = 0; i < 15; i++) begin
            step(vt[i].r, vt[i].en, vt[i].we, vt[i].a, vt[i].d, 1'b0, 1'b0, 8'h00, 21'h0);
            check($sformatf("vec%0d", i), dbus.douta, vt[i].exp);
            check($sformatf("vec%0d_model", i), dbus.douta, exp_d);
            if (i == 0) check("tagv_after_reset", {11'h0, tbus.douta}, 32'h0);
        end

        tag_step(1'b1, 1'b0, 8'h00, 21'h0);
        check("tagv_rd_00", {11'h0, tbus.douta}, 32'h0);
        tag_step(1'b1, 1'b0, 8'hFF, 21'h0);
        check("tagv_rd_ff", {11'h0, tbus.douta}, 32'h0);
        tag_step(1'b1, 1'b1, 8'h7F, 21'h1ABCDE);
        check("tagv_wr_7f_old", {11'h0, tbus.douta}, 32'h0);
        tag_step(1'b1, 1'b0, 8'h7F, 21'h000001);
        check("tagv_rd_7f", {11'h0, tbus.douta}, 32'h001ABCDE);
        tag_step(1'b0, 1'b1, 8'h7F, 21'h000002);
        check("tagv_disabled_hold", {11'h0, tbus.douta}, 32'h001ABCDE);
        tag_step(1'b1, 1'b0, 8'h7F, 21'h0);
        check("tagv_rd_7f_again", {11'h0, tbus.douta}, 32'h001ABCDE);

        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 31) == 0,
                 $urandom_range(0, 3) != 0, 4'($urandom), 8'($urandom_range(0, 15)), $urandom,
                 $urandom_range(0, 3) != 0, 1'($urandom), 8'($urandom_range(120, 135)), 21'($urandom));
            check($sformatf("rand%0d_data", n), dbus.douta, exp_d);
            check($sformatf("rand%0d_tagv", n), {11'h0, tbus.douta}, {11'h0, exp_t});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cache_sp_ram.md
# cache_sp_ram

Parameterized single-port synchronous RAM used as the storage primitive inside each cache way. It is instantiated twice per way with different parameters:
- data banks: 4 × 32-bit banks, 4 byte-write lanes, 256 entries;
- tag/valid array: 21-bit `{v, tag[19:0]}`, 1 write lane, 256 entries.

It reads first, has one cycle of read latency, and supports per-lane write enables.

## Interface
Parameters:
- `DATA_W`, default 32: word width in bits (tag/valid instance uses 21).
- `ADDR_W`, default 8: address width; depth = 2^ADDR_W (256 for cache index width).
- `WE_W`, default 4: number of write-enable lanes.
  - Lane width = ceil(DATA_W/WE_W).
  - The last lane covers the remaining upper bits.
  - The tag/valid instance uses 1.

Ports (one clock; reset is synchronous and active-high):
- `clka`  in  1  clock; all state changes on its rising edge.
- `rsta`  in  1  synchronous active-high reset.
- `ena`  in  1  port enable; no read or write occurs when low.
- `wea`  in  WE_W  per-lane write enables; bit k covers bits [k·LW +: LW].
- `addra`  in  ADDR_W  read/write address.
- `dina`  in  DATA_W  write data.
- `douta`  out  DATA_W  registered read data.

## Operation
- Storage is DEPTH × DATA_W. Every entry holds 0 at time zero, so the valid bit reads as 0 before any fill.
- **Reset.** When `rsta`=1 at a rising edge:
  - `douta` becomes 0.
  - Memory contents are not cleared.
  - Writes in that cycle are suppressed.
- **Read.** When `ena`=1 and `rsta`=0, `douta` takes `mem[addra]` at the edge, using the value held before any write in the same cycle (read-first).
- **Write.** When `ena`=1 and `rsta`=0, each lane k with `wea[k]`=1 updates `mem[addra]` lane k from `dina` lane k. Lanes with `wea[k]`=0 are unchanged.
  - `wea` all-zero is a pure read.
  - `wea` all-ones is a full-word write.
- **Disabled.** When `ena`=0, `douta` holds its previous value and memory is unchanged, whatever `wea`, `addra` and `dina` are.
- **Addressing.** There is no wrap or out-of-range case: `addra` always covers the full depth.
- **Use model.** The caller arbitrates the single port.
  - Full-line refill drives all banks with `wea`=1111.
  - A partial store enables only the bank selected by offset[3:2], with the store's byte strobes.
  - Plain lookup drives the read index with `wea`=0.

## Timing
- Read latency is 1 cycle. Data for address A presented at edge N is valid on `douta` after edge N, until the next enabled edge.
- A write takes effect at the edge. A read of the same address at edge N+1 returns the new data.
- Simultaneous read and write of the same address in one cycle returns the old data (read-first).
- Reset takes priority over `ena`.
- `douta` after reset is 0 until the first enabled read.
- There are no combinational paths from inputs to `douta`.

## Structure
- The shared cache package holds:
  - `CACHE_INDEX_W` = 8;
  - `CACHE_OFFSET_W` = 4;
  - `CACHE_TAG_W` = 20;
  - `CACHE_TAGV_W` = 21;
  - `CACHE_BANK_W` = 32;
  - `CACHE_BANKS` = 4.
- The RAM needs no sub-module. Lane writes are a generate loop over WE_W with per-lane slicing; the partial top lane is handled by clamping its width.
- The instances used by the cache way are:
  - data bank: `DATA_W`=32, `ADDR_W`=8, `WE_W`=4;
  - tag/valid: `DATA_W`=21, `ADDR_W`=8, `WE_W`=1.

## Test plan
- **Power-up read.** Reset 1 cycle, then read addr 0x00 and 0xFF on the tag/valid instance -> `douta` = 0 after reset and 0x000000 after each read.
- **Full write then read (data instance).** Write 0xDEADBEEF at 0x12 with `wea`=1111, then read 0x12 -> `douta` = 0xDEADBEEF one cycle after the read edge.
- **Byte lanes.** Preload 0x11223344 at 0x05, write 0xAABBCCDD with `wea`=0101, then read -> 0x11BB33DD.
- **Read-first.** 0x20 holds 0x0000CAFE; write 0x12345678 to 0x20 with `wea`=1111 in one cycle:
  - `douta` after that edge = 0x0000CAFE;
  - the next read returns 0x12345678.
- **Enable low.** With `ena`=0, `wea`=1111, `dina`=0xFFFFFFFF at 0x12 -> `douta` holds, and a later read of 0x12 still returns 0xDEADBEEF.
- **Reset mid-operation.** Assert `rsta` with `ena`=1, `wea`=1111, `dina`=0x55555555 at 0x12 -> `douta` = 0, and a later read of 0x12 returns 0xDEADBEEF. Separately, a tag/valid write of 0x1ABCDE at 0x7F reads back 0x1ABCDE.
